// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the 5-stage RISC-V core.
// Word-only (LW/SW) data memory with combinational read, a synchronous write,
// the MEM/WB pipeline register and the combinational writeback mux (ResultW).
module memory_cycle #(
  parameter int DMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic        MemErrW
);

  logic [31:0]       mem_q [DMEM_DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic              aligned;
  logic              in_range;
  logic              addr_ok;
  logic [31:0]       rdata;

  logic              regwrite_q,  regwrite_d;
  logic              resultsrc_q, resultsrc_d;
  logic [4:0]        rd_q,        rd_d;
  logic [31:0]       pcplus4_q,   pcplus4_d;
  logic [31:0]       aluresult_q, aluresult_d;
  logic [31:0]       readdata_q,  readdata_d;
  logic              memerr_q,    memerr_d;

  // Address decode and combinational read; invalid addresses read as zero so
  // an out-of-range load never aliases onto a real word.
  always_comb begin
    word_idx = ALU_ResultM[ADDR_W+1:2];
    aligned  = (ALU_ResultM[1:0] == 2'b00);
    in_range = (ALU_ResultM[31:ADDR_W+2] == '0);
    addr_ok  = aligned & in_range;
    rdata    = addr_ok ? mem_q[word_idx] : 32'h0;
  end

  // Data memory: reset clears every word; stores to invalid addresses are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (MemWriteM && addr_ok) begin
      mem_q[word_idx] <= WriteDataM;
    end
  end

  // MEM/WB next state: straight capture of the M-stage fields plus load data.
  // The error flag only fires when the instruction actually touches memory.
  always_comb begin
    regwrite_d  = RegWriteM;
    resultsrc_d = ResultSrcM;
    rd_d        = RD_M;
    pcplus4_d   = PCPlus4M;
    aluresult_d = ALU_ResultM;
    readdata_d  = rdata;
    memerr_d    = ~addr_ok & (MemWriteM | ResultSrcM);
  end

  // ---- M -> W pipeline boundary ----
  // MEM/WB register, no stall: every non-reset edge advances the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= 5'd0;
      pcplus4_q   <= 32'h0;
      aluresult_q <= 32'h0;
      readdata_q  <= 32'h0;
      memerr_q    <= 1'b0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pcplus4_q   <= pcplus4_d;
      aluresult_q <= aluresult_d;
      readdata_q  <= readdata_d;
      memerr_q    <= memerr_d;
    end
  end

  // Writeback mux straight off the W registers; also the forwarding source.
  always_comb begin
    ResultW = resultsrc_q ? readdata_q : aluresult_q;
  end

  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pcplus4_q;
  assign ALU_ResultW = aluresult_q;
  assign ReadDataW   = readdata_q;
  assign MemErrW     = memerr_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: a word-array model tracks the memory
// and the expected W outputs; a compare process checks every cycle, and
// directed literal checks pin the model against hand-computed values.
module tb_memory_cycle;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW, ResultSrcW, MemErrW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

  memory_cycle #(.DMEM_DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .ResultW(ResultW), .MemErrW(MemErrW)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: memory as a plain word array indexed by byte address / 4.
  logic [31:0] m [DEPTH];
  logic        e_rw, e_rs, e_err;
  logic [4:0]  e_rd;
  logic [31:0] e_pc, e_alu, e_rdat, e_res;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m[i]) m[i] <= 32'h0;
      e_rw <= 1'b0; e_rs <= 1'b0; e_err <= 1'b0; e_rd <= 5'd0;
      e_pc <= 32'h0; e_alu <= 32'h0; e_rdat <= 32'h0; e_res <= 32'h0;
    end else begin
      automatic bit ok = (ALU_ResultM % 4 == 0) && (ALU_ResultM < DEPTH * 4);
      automatic logic [31:0] ld = ok ? m[ALU_ResultM / 4] : 32'h0;
      if (MemWriteM && ok) m[ALU_ResultM / 4] <= WriteDataM;
      e_rw   <= RegWriteM;
      e_rs   <= ResultSrcM;
      e_rd   <= RD_M;
      e_pc   <= PCPlus4M;
      e_alu  <= ALU_ResultM;
      e_rdat <= ld;
      e_res  <= ResultSrcM ? ld : ALU_ResultM;
      e_err  <= !ok && (MemWriteM || ResultSrcM);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("RegWriteW",   {31'b0, RegWriteW},  {31'b0, e_rw});
      chk("ResultSrcW",  {31'b0, ResultSrcW}, {31'b0, e_rs});
      chk("RD_W",        {27'b0, RD_W},       {27'b0, e_rd});
      chk("PCPlus4W",    PCPlus4W,            e_pc);
      chk("ALU_ResultW", ALU_ResultW,         e_alu);
      chk("ReadDataW",   ReadDataW,           e_rdat);
      chk("ResultW",     ResultW,             e_res);
      chk("MemErrW",     {31'b0, MemErrW},    {31'b0, e_err});
    end
  end

  task automatic step(input logic r, input logic we, input logic rs, input logic rw,
                      input logic [4:0] rd, input logic [31:0] pc,
                      input logic [31:0] wd, input logic [31:0] alu);
    @(negedge clk);
    #1;
    rst = r; MemWriteM = we; ResultSrcM = rs; RegWriteM = rw;
    RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    step(0, 1, 0, 0, 5'd0, 32'h0, d, a);
  endtask

  task automatic lw(input logic [31:0] a);
    step(0, 0, 1, 1, 5'd1, 32'h0, 32'h0, a);
  endtask

  initial begin
    // Reset with a store pending: it must be discarded.
    rst = 1; MemWriteM = 1; ResultSrcM = 0; RegWriteM = 1; RD_M = 5'd7;
    PCPlus4M = 32'h4; WriteDataM = 32'hDEADBEEF; ALU_ResultM = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst RegWriteW", {31'b0, RegWriteW}, 32'h0);
    chk("rst RD_W",      {27'b0, RD_W},      32'h0);
    chk("rst PCPlus4W",  PCPlus4W,           32'h0);
    chk("rst ALU_ResultW", ALU_ResultW,      32'h0);
    chk("rst ResultW",   ResultW,            32'h0);
    chk("rst MemErrW",   {31'b0, MemErrW},   32'h0);

    step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h10); settle;
    chk("post-rst load 0x10", ReadDataW, 32'h0);

    // Store then load-after-store of the same word.
    sw(32'h20, 32'h12345678);
    step(0, 0, 1, 1, 5'd5, 32'h0, 32'h0, 32'h20); settle;
    chk("lw 0x20 ReadDataW", ReadDataW, 32'h12345678);
    chk("lw 0x20 ResultW",   ResultW,   32'h12345678);
    chk("lw 0x20 RD_W",      {27'b0, RD_W}, 32'd5);
    chk("lw 0x20 RegWriteW", {31'b0, RegWriteW}, 32'h1);
    chk("lw 0x20 MemErrW",   {31'b0, MemErrW}, 32'h0);

    // ALU passthrough.
    step(0, 0, 0, 1, 5'd3, 32'h8, 32'h0, 32'h30); settle;
    chk("alu ALU_ResultW", ALU_ResultW, 32'h30);
    chk("alu ResultW",     ResultW,     32'h30);
    chk("alu PCPlus4W",    PCPlus4W,    32'h8);

    // Misaligned store is flagged and suppressed.
    sw(32'h22, 32'hAAAAAAAA); settle;
    chk("misaligned sw MemErrW", {31'b0, MemErrW}, 32'h1);
    lw(32'h20); settle;
    chk("lw 0x20 after misaligned", ReadDataW, 32'h12345678);

    // Out of range: 0x1000 would alias word 0 if the upper bits were ignored.
    lw(32'h1000); settle;
    chk("oor lw ReadDataW", ReadDataW, 32'h0);
    chk("oor lw MemErrW",   {31'b0, MemErrW}, 32'h1);
    sw(32'h1000, 32'h55555555); settle;
    chk("oor sw MemErrW", {31'b0, MemErrW}, 32'h1);
    lw(32'h0); settle;
    chk("word 0 after oor sw", ReadDataW, 32'h0);
    // Invalid address without a memory access flags nothing.
    step(0, 0, 0, 1, 5'd2, 32'h0, 32'h0, 32'h1001); settle;
    chk("invalid non-mem MemErrW", {31'b0, MemErrW}, 32'h0);

    // Back-to-back stores, including the last word, then readback.
    sw(32'h0, 32'h11111111);
    sw(32'h4, 32'h22222222);
    sw(32'hFFC, 32'h33333333);
    lw(32'h0);   settle; chk("b2b lw 0x0",   ReadDataW, 32'h11111111);
    lw(32'h4);   settle; chk("b2b lw 0x4",   ReadDataW, 32'h22222222);
    lw(32'hFFC); settle; chk("b2b lw 0xFFC", ResultW,   32'h33333333);
    lw(32'hFFE); settle; chk("lw 0xFFE MemErrW", {31'b0, MemErrW}, 32'h1);

    // Reset mid-stream clears every word.
    step(1, 1, 0, 0, 5'd0, 32'h0, 32'h77777777, 32'h4);
    lw(32'h0);   settle; chk("rst2 lw 0x0",   ReadDataW, 32'h0);
    lw(32'h4);   settle; chk("rst2 lw 0x4",   ReadDataW, 32'h0);
    lw(32'hFFC); settle; chk("rst2 lw 0xFFC", ReadDataW, 32'h0);
    lw(32'h20);  settle; chk("rst2 lw 0x20",  ReadDataW, 32'h0);

    step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Fourth pipeline stage of the 5-stage RISC-V core, directly downstream of execute_cycle.
- Consumes the EX/MEM outputs of execute_cycle, performs word loads and stores against an internal data memory, and holds the MEM/WB pipeline register.
- Produces ResultW combinationally; this is the value fed back to execute_cycle's ResultW forwarding input and to the register file write port.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit words in data memory (power of two, >= 4).
- ADDR_W, 10, log2(DMEM_DEPTH); word-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- RegWriteM  in  1  register-write enable from EX/MEM.
- MemWriteM  in  1  store enable.
- ResultSrcM  in  1  0 selects ALU result, 1 selects load data.
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the instruction.
- WriteDataM  in  32  store data, already forwarded.
- ALU_ResultM  in  32  byte address for load/store, or ALU result.
- RegWriteW  out  1  registered RegWriteM.
- ResultSrcW  out  1  registered ResultSrcM.
- RD_W  out  5  registered RD_M.
- PCPlus4W  out  32  registered PCPlus4M.
- ALU_ResultW  out  32  registered ALU_ResultM.
- ReadDataW  out  32  registered load data.
- ResultW  out  32  combinational: ResultSrcW ? ReadDataW : ALU_ResultW.
- MemErrW  out  1  registered error flag, asserted for a misaligned or out-of-range store or load in M.

Behaviour:
- Clocking: clk and rst are the only clock and reset. Reset is synchronous and active-high: rst sampled high on a rising clk edge resets the block. No other clocks.
- Reset: on any edge with rst=1:
  - RegWriteW, ResultSrcW and MemErrW go to 0.
  - RD_W, PCPlus4W, ALU_ResultW and ReadDataW go to 0.
  - All DMEM_DEPTH memory words are cleared to 0.
  - A store presented in that same cycle is discarded.
  - ResultW is therefore 0 after reset.
- Address decode:
  - word index = ALU_ResultM[ADDR_W+1:2].
  - aligned = (ALU_ResultM[1:0] == 0).
  - in_range = (ALU_ResultM[31:ADDR_W+2] == 0).
  - valid = aligned & in_range.
- Read path:
  - Memory read is combinational on the word index.
  - rdata = valid ? mem[index] : 32'h0.
  - rdata is evaluated every cycle regardless of ResultSrcM.
- Store: on a rising edge with rst=0, MemWriteM=1 and valid=1, mem[index] <= WriteDataM. If valid=0 the store is suppressed and memory is unchanged.
- Error flag: MemErrW <= ~valid & (MemWriteM | ResultSrcM). An invalid address with neither a store nor a load flags nothing.
- MEM/WB register: on every non-reset edge, all *W registers load their M counterparts; ReadDataW <= rdata.
  - Latency: exactly 1 cycle from M inputs to W outputs.
  - No stall or enable input.
- Read-during-write: a same-cycle load and store to the same word cannot both occur (single instruction per stage). A store at edge N followed by a load of the same word at edge N+1 returns the new data in ReadDataW after edge N+1.
- The error flag does not gate RegWriteW. Trapping on MemErrW is left to the hazard/control unit.
- ResultW: pure mux of the W registers. It must be glitch-consistent within the cycle the registers update and has no extra register.
- Width rules: all 32-bit fields pass through unmodified. No byte/halfword access and no sign extension; the block supports LW/SW only.

Test Plan:
- Reset: drive rst=1 for 2 edges with MemWriteM=1, ALU_ResultM=0x10, WriteDataM=0xDEADBEEF -> all W outputs 0, ResultW=0; then rst=0, ResultSrcM=1, ALU_ResultM=0x10 -> ReadDataW=0 (store discarded, memory cleared).
- Store/load: SW 0x12345678 to 0x20, next cycle LW 0x20 with RD_M=5, RegWriteM=1 -> one edge later ReadDataW=0x12345678, ResultW=0x12345678, RD_W=5, RegWriteW=1, MemErrW=0.
- ALU passthrough: ResultSrcM=0, ALU_ResultM=0x30, PCPlus4M=0x8 -> next edge ALU_ResultW=0x30, ResultW=0x30, PCPlus4W=0x8.
- Misaligned store: SW 0xAAAAAAAA to 0x22 -> MemErrW=1 next edge; LW 0x20 returns the prior contents (0x12345678), not 0xAAAAAAAA.
- Out of range: with DMEM_DEPTH=1024, LW from 0x1000 -> ReadDataW=0, MemErrW=1; SW to 0x1000 -> no word in memory changes (readback of 0x0 is unchanged).
- Back-to-back and reset mid-stream: stores to 0x0, 0x4, 0xFFC on consecutive cycles, then loads read back all three; asserting rst between them clears every word to 0.
